// File: rtl/irq_ctrl_pkg.sv
// Shared constants and types for the interrupt controller.
package irq_ctrl_pkg;

  // Default number of interrupt sources, wired to CP0 HWInt[7:2].
  localparam int N_SRC_DEF = 6;

  // Width of a source index; covers up to 8 sources.
  localparam int SEL_W = 3;

  // Register word offsets (bridge byte address [3:2]).
  localparam logic [1:0] ADDR_MASK = 2'd0;
  localparam logic [1:0] ADDR_EDGE = 2'd1;
  localparam logic [1:0] ADDR_PEND = 2'd2;
  localparam logic [1:0] ADDR_STAT = 2'd3;

  // STAT register layout.
  localparam int STAT_IDX_LSB  = 0;
  localparam int STAT_BUSY_BIT = 8;

  // Request handshake states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_SERV = 2'd2
  } state_e;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: lowest set index wins (bit 0 highest priority).
module irq_prio_enc
  import irq_ctrl_pkg::*;
#(
  parameter int N = N_SRC_DEF
) (
  input  logic [N-1:0]     req_i,
  output logic [SEL_W-1:0] idx_o,
  output logic             vld_o
);

  // Scan from the top down so the lowest asserted index is the last one written.
  always_comb begin
    idx_o = '0;
    vld_o = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o = SEL_W'(i);
        vld_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: per-source mask and edge/level capture, fixed-priority
// selection, and a REQ/ack/EOI handshake that drives a one-hot CP0 request.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int N_SRC = N_SRC_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] src_irq,
  input  logic [1:0]       addr,
  input  logic             we,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  input  logic             int_ack,
  output logic [N_SRC-1:0] hw_int
);

  logic [N_SRC-1:0] mask_q, edge_q, pend_q, prev_q, pend_d;
  logic [N_SRC-1:0] rise, w1c, ack_clr, sel_oh, sel_oh_d, hw_int_q, hw_int_d;
  logic [SEL_W-1:0] sel_q, sel_d, insvc_q, insvc_d, enc_idx;
  logic             enc_vld, sel_live;
  logic             wr_mask, wr_edge, wr_pend, wr_eoi;
  state_e           state_q, state_d;
  logic             unused_wdata;

  assign wr_mask = we && (addr == ADDR_MASK);
  assign wr_edge = we && (addr == ADDR_EDGE);
  assign wr_pend = we && (addr == ADDR_PEND);
  assign wr_eoi  = we && (addr == ADDR_STAT);

  // Write data above the implemented sources is intentionally dropped.
  assign unused_wdata = ^wdata[31:N_SRC];

  assign rise     = src_irq & ~prev_q;
  assign w1c      = wr_pend ? wdata[N_SRC-1:0] : '0;
  assign sel_oh   = N_SRC'(1) << sel_q;
  assign ack_clr  = ((state_q == ST_REQ) && int_ack) ? sel_oh : '0;
  assign sel_live = |(pend_q & mask_q & sel_oh);

  // Edge bits: clear by W1C or ack, then a new rising edge overrides the clear.
  // Level bits: simply follow the sampled line.
  assign pend_d = (edge_q & ((pend_q & ~w1c & ~ack_clr) | rise)) |
                  (~edge_q & src_irq);

  irq_prio_enc #(.N(N_SRC)) u_prio (
    .req_i (pend_q & mask_q),
    .idx_o (enc_idx),
    .vld_o (enc_vld)
  );

  // Next-state logic for the request handshake; sel only moves when leaving IDLE.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    insvc_d = insvc_q;
    case (state_q)
      ST_IDLE: begin
        if (enc_vld) begin
          sel_d   = enc_idx;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (int_ack) begin
          insvc_d = sel_q;
          state_d = ST_SERV;
        end else if (!sel_live) begin
          state_d = ST_IDLE;
        end
      end
      ST_SERV: begin
        if (wr_eoi) begin
          insvc_d = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign sel_oh_d = N_SRC'(1) << sel_d;
  assign hw_int_d = (state_d == ST_REQ) ? sel_oh_d : '0;

  // Source sampling and software-visible register state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mask_q <= '0;
      edge_q <= '0;
      pend_q <= '0;
      prev_q <= '0;
    end else begin
      if (wr_mask) mask_q <= wdata[N_SRC-1:0];
      if (wr_edge) edge_q <= wdata[N_SRC-1:0];
      pend_q <= pend_d;
      prev_q <= src_irq;
    end
  end

  // Handshake state and the registered CP0 request line.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      sel_q    <= '0;
      insvc_q  <= '0;
      hw_int_q <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      insvc_q  <= insvc_d;
      hw_int_q <= hw_int_d;
    end
  end

  assign hw_int = hw_int_q;

  // Register read mux; unimplemented bits read as zero.
  always_comb begin
    rdata = '0;
    case (addr)
      ADDR_MASK: rdata[N_SRC-1:0] = mask_q;
      ADDR_EDGE: rdata[N_SRC-1:0] = edge_q;
      ADDR_PEND: rdata[N_SRC-1:0] = pend_q;
      ADDR_STAT: begin
        rdata[STAT_IDX_LSB +: SEL_W] = insvc_q;
        rdata[STAT_BUSY_BIT]         = (state_q == ST_SERV);
      end
      default: rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: directed scenarios with literal expectations plus a
// per-cycle comparison against a behavioural model of the register/handshake rules.
module tb_irq_ctrl;

  logic        clk;
  logic        rst;
  logic [5:0]  src_irq;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        int_ack;
  logic [5:0]  hw_int;

  int checks = 0;
  int errors = 0;

  irq_ctrl #(.N_SRC(6)) dut (
    .clk     (clk),
    .rst     (rst),
    .src_irq (src_irq),
    .addr    (addr),
    .we      (we),
    .wdata   (wdata),
    .rdata   (rdata),
    .int_ack (int_ack),
    .hw_int  (hw_int)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // phase: 0 = nothing requested, 1 = request raised to CPU, 2 = in service
  logic [5:0] m_mask = '0, m_edge = '0, m_pend = '0, m_prev = '0, m_hw = '0;
  int         m_phase = 0, m_sel = 0, m_svc = 0;
  logic [5:0] n_pend, n_hw, cand, lowest;
  int         n_phase, n_sel, n_svc;

  always_comb begin
    n_pend  = '0;
    n_phase = m_phase;
    n_sel   = m_sel;
    n_svc   = m_svc;
    for (int i = 0; i < 6; i++) begin
      if (!m_edge[i]) begin
        n_pend[i] = src_irq[i];
      end else begin
        n_pend[i] = m_pend[i];
        if (we && addr == 2'd2 && wdata[i]) n_pend[i] = 1'b0;
        if (m_phase == 1 && int_ack && m_sel == i) n_pend[i] = 1'b0;
        if (src_irq[i] && !m_prev[i]) n_pend[i] = 1'b1;
      end
    end
    cand   = m_pend & m_mask;
    lowest = cand & (~cand + 6'd1);
    if (m_phase == 0) begin
      if (cand != 0) begin
        n_sel   = $clog2(lowest);
        n_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (int_ack) begin
        n_svc   = m_sel;
        n_phase = 2;
      end else if (!(m_pend[m_sel] && m_mask[m_sel])) begin
        n_phase = 0;
      end
    end else begin
      if (we && addr == 2'd3) begin
        n_svc   = 0;
        n_phase = 0;
      end
    end
    n_hw = (n_phase == 1) ? (6'd1 << n_sel) : 6'd0;
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_mask <= '0; m_edge <= '0; m_pend <= '0; m_prev <= '0; m_hw <= '0;
      m_phase <= 0; m_sel <= 0; m_svc <= 0;
    end else begin
      if (we && addr == 2'd0) m_mask <= wdata[5:0];
      if (we && addr == 2'd1) m_edge <= wdata[5:0];
      m_pend  <= n_pend;
      m_prev  <= src_irq;
      m_phase <= n_phase;
      m_sel   <= n_sel;
      m_svc   <= n_svc;
      m_hw    <= n_hw;
    end
  end

  function automatic logic [31:0] m_read(input logic [1:0] a);
    case (a)
      2'd0:    return {26'd0, m_mask};
      2'd1:    return {26'd0, m_edge};
      2'd2:    return {26'd0, m_pend};
      default: return ((m_phase == 2) ? 32'h100 : 32'h0) | 32'(m_svc);
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("model_hw_int", {26'd0, hw_int}, {26'd0, m_hw});
    chk("model_rdata", rdata, m_read(addr));
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    we = 1'b1; addr = a; wdata = d;
    tick();
    we = 1'b0; wdata = '0;
  endtask

  task automatic peek(input logic [1:0] a, input logic [31:0] exp, input string name);
    addr = a;
    #1;
    chk(name, rdata, exp);
  endtask

  task automatic hw_is(input logic [5:0] exp, input string name);
    chk(name, {26'd0, hw_int}, {26'd0, exp});
  endtask

  task automatic ack();
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    rst = 1'b0; src_irq = '0; addr = '0; we = 1'b0; wdata = '0; int_ack = 1'b0;
    tick(); tick();
    hw_is(6'h00, "reset_hw");
    peek(2'd0, 32'h0, "reset_mask");
    peek(2'd3, 32'h0, "reset_stat");
    tick();
    rst = 1'b1;
    tick();

    // Single edge source: latency, ack, EOI.
    wr(2'd0, 32'h01);
    wr(2'd1, 32'h01);
    src_irq = 6'h01; tick(); src_irq = 6'h00;
    peek(2'd2, 32'h01, "edge_pend_set");
    hw_is(6'h00, "edge_hw_n1");
    tick();
    hw_is(6'h01, "edge_hw_n2");
    ack();
    hw_is(6'h00, "edge_hw_after_ack");
    peek(2'd2, 32'h00, "edge_pend_cleared");
    peek(2'd3, 32'h100, "edge_stat_busy");
    wr(2'd3, 32'h0);
    peek(2'd3, 32'h000, "edge_stat_eoi");

    // Simultaneous edges: bit 0 first, bit 1 two cycles after EOI.
    wr(2'd0, 32'h03);
    wr(2'd1, 32'h03);
    src_irq = 6'h03; tick(); src_irq = 6'h00;
    tick();
    hw_is(6'h01, "prio_first");
    ack();
    peek(2'd2, 32'h02, "prio_pend_left");
    wr(2'd3, 32'h0);
    hw_is(6'h00, "prio_eoi_plus1");
    tick();
    hw_is(6'h02, "prio_second");

    // Freeze: higher-priority arrival while bit 1 is requested.
    src_irq = 6'h01; tick(); src_irq = 6'h00;
    tick();
    hw_is(6'h02, "freeze_hold");
    peek(2'd2, 32'h03, "freeze_pend");
    ack();
    peek(2'd3, 32'h101, "freeze_stat");
    wr(2'd3, 32'h0);
    tick();
    hw_is(6'h01, "freeze_next");
    ack();
    wr(2'd3, 32'h0);
    tick();

    // Level source withdrawn before ack.
    wr(2'd1, 32'h00);
    wr(2'd0, 32'h02);
    src_irq = 6'h02; tick();
    tick();
    hw_is(6'h02, "level_req");
    tick();
    src_irq = 6'h00; tick();
    tick();
    hw_is(6'h00, "level_withdrawn");
    peek(2'd2, 32'h00, "level_pend");
    peek(2'd3, 32'h00, "level_stat_idle");

    // Unimplemented high bits ignore writes.
    wr(2'd0, 32'hFFFF_FFFF);
    peek(2'd0, 32'h3F, "mask_high_bits");
    wr(2'd0, 32'h00);

    // W1C colliding with a fresh edge on the same bit.
    wr(2'd1, 32'h01);
    src_irq = 6'h01; tick(); src_irq = 6'h00;
    tick();
    peek(2'd2, 32'h01, "w1c_pre");
    src_irq = 6'h01; we = 1'b1; addr = 2'd2; wdata = 32'h01;
    tick();
    we = 1'b0; wdata = '0; src_irq = 6'h00;
    peek(2'd2, 32'h01, "w1c_race_set_wins");
    wr(2'd2, 32'h01);
    peek(2'd2, 32'h00, "w1c_plain");

    // Reset while in service with more work pending.
    wr(2'd0, 32'h03);
    wr(2'd1, 32'h03);
    src_irq = 6'h03; tick(); src_irq = 6'h00;
    tick();
    ack();
    src_irq = 6'h01; tick(); src_irq = 6'h00;
    peek(2'd2, 32'h03, "rst_pre_pend");
    peek(2'd3, 32'h100, "rst_pre_stat");
    tick();
    rst = 1'b0;
    #1;
    hw_is(6'h00, "rst_hw_now");
    peek(2'd0, 32'h0, "rst_mask_now");
    peek(2'd2, 32'h0, "rst_pend_now");
    tick();
    peek(2'd1, 32'h0, "rst_edge_now");
    peek(2'd3, 32'h0, "rst_stat_now");
    tick();
    rst = 1'b1;
    repeat (4) tick();
    hw_is(6'h00, "post_rst_quiet");
    peek(2'd2, 32'h0, "post_rst_pend");

    // Fresh request after reset on a higher index.
    wr(2'd1, 32'h04);
    wr(2'd0, 32'h04);
    src_irq = 6'h04; tick(); src_irq = 6'h00;
    tick();
    hw_is(6'h04, "post_rst_new_req");
    ack();
    wr(2'd3, 32'h0);
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
